// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: 16x oversampling, start-bit validation and 3-sample majority vote per bit.
// Emits a one-clk rx_done with the byte, or a one-clk frame_err when the stop bit is low.
module uart_byte_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] baud_set,
  input  logic       rs232_rx,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       uart_state
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic        rx_s1, rx_s2, rx_d;
  logic [8:0]  div_sel, div_max, div_cnt;
  logic [3:0]  sample_cnt;
  logic [2:0]  bit_cnt;
  logic [2:0]  vote;
  logic [7:0]  shreg;
  logic        fall, tick, bit_val;

  // Synchronizer and edge register reset high so reset release never looks like a start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rs232_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign fall    = rx_d & ~rx_s2;
  assign tick    = (state != IDLE) && (div_cnt == div_max);
  assign bit_val = (vote[0] & vote[1]) | (vote[0] & vote[2]) | (vote[1] & vote[2]);

  always_comb begin
    case (baud_set)
      4'd0:    div_sel = 9'd324;
      4'd1:    div_sel = 9'd162;
      4'd2:    div_sel = 9'd80;
      4'd3:    div_sel = 9'd53;
      4'd4:    div_sel = 9'd26;
      4'd15:   div_sel = 9'd1;
      default: div_sel = 9'd324;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      div_max    <= 9'd324;
      div_cnt    <= '0;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      vote       <= '0;
      shreg      <= '0;
      data_byte  <= '0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      uart_state <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE) begin
        div_cnt    <= '0;
        sample_cnt <= '0;
        if (fall) begin
          div_max    <= div_sel;
          state      <= START;
          uart_state <= 1'b1;
        end
      end else begin
        div_cnt <= tick ? 9'd0 : div_cnt + 9'd1;
        if (tick) begin
          sample_cnt <= sample_cnt + 4'd1;
          case (sample_cnt)
            4'd7:    vote[0] <= rx_s2;
            4'd8:    vote[1] <= rx_s2;
            4'd9:    vote[2] <= rx_s2;
            default: ;
          endcase
          case (state)
            START: begin
              if (sample_cnt == 4'd10 && bit_val) begin
                state      <= IDLE;
                uart_state <= 1'b0;
              end else if (sample_cnt == 4'd15) begin
                state   <= DATA;
                bit_cnt <= '0;
              end
            end
            DATA: begin
              if (sample_cnt == 4'd10)
                shreg <= {bit_val, shreg[7:1]};
              if (sample_cnt == 4'd15) begin
                if (bit_cnt == 3'd7) state <= STOP;
                else                 bit_cnt <= bit_cnt + 3'd1;
              end
            end
            STOP: begin
              // Leave mid-stop-bit so a following start edge is never missed
              if (sample_cnt == 4'd10) begin
                if (bit_val) begin
                  data_byte <= shreg;
                  rx_done   <= 1'b1;
                end else begin
                  frame_err <= 1'b1;
                end
                state      <= IDLE;
                uart_state <= 1'b0;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: a serial driver pushes expected results to a scoreboard queue,
// a collector pops and compares whenever the receiver strobes.
module tb_uart_byte_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] baud_set = 4'd15;
  logic       rs232_rx = 1'b1;
  logic [7:0] data_byte;
  logic       rx_done, frame_err, uart_state;

  uart_byte_rx dut (
    .clk(clk), .rst(rst), .baud_set(baud_set), .rs232_rx(rs232_rx),
    .data_byte(data_byte), .rx_done(rx_done), .frame_err(frame_err), .uart_state(uart_state)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] last_good = 8'h00;
  int         checks = 0;
  int         passed = 0;

  // Passive protocol monitor: counts only, judged by test_invariants
  int         n_done = 0, n_err = 0, n_both = 0, n_state_bad = 0, n_wide = 0, n_data_bad = 0;
  logic       strobe_q = 1'b0;
  logic [7:0] data_q = 8'h00;
  always @(negedge clk) begin
    if (rx_done) n_done++;
    if (frame_err) n_err++;
    if (rx_done && frame_err) n_both++;
    if ((rx_done || frame_err) && uart_state) n_state_bad++;
    if ((rx_done || frame_err) && strobe_q) n_wide++;
    if (!rst && !rx_done && data_byte !== data_q) n_data_bad++;
    strobe_q = rx_done | frame_err;
    data_q   = data_byte;
  end

  task automatic send_byte(input logic [7:0] b, input int bit_clks, input logic stop_bit,
                           input int glitch_at);
    logic v;
    exp_t e;
    e.err  = ~stop_bit;
    e.data = stop_bit ? b : last_good;
    sb.push_back(e);
    if (stop_bit) last_good = b;
    for (int i = 0; i < 10; i++) begin
      v = (i == 0) ? 1'b0 : (i == 9) ? stop_bit : b[i-1];
      for (int c = 0; c < bit_clks; c++) begin
        rs232_rx = (glitch_at == i * bit_clks + c) ? ~v : v;
        @(posedge clk); #1;
      end
    end
    rs232_rx = 1'b1;
  endtask

  task automatic collect(input int n, input int budget);
    exp_t e;
    int   k;
    for (int f = 0; f < n; f++) begin
      k = 0;
      do begin @(negedge clk); k++; end while (!(rx_done || frame_err) && k < budget);
      checks++;
      if (!(rx_done || frame_err)) begin
        $display("FAIL collect_timeout frame=%0d: no strobe within %0d clks", f, budget);
        if (sb.size() != 0) void'(sb.pop_front());
      end else if (sb.size() == 0) begin
        $display("FAIL collect_unexpected: strobe err=%0b data=%02h with empty scoreboard",
                 frame_err, data_byte);
      end else begin
        e = sb.pop_front();
        if (frame_err !== e.err || data_byte !== e.data)
          $display("FAIL collect frame=%0d: got err=%0b data=%02h, expected err=%0b data=%02h",
                   f, frame_err, data_byte, e.err, e.data);
        else passed++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int d0, e0;
    rst = 1'b1; rs232_rx = 1'b1; baud_set = 4'd15;
    idle(3);
    checks++; if (data_byte !== 8'h00) $display("FAIL reset_data: got %02h expected 00", data_byte); else passed++;
    checks++; if (rx_done !== 1'b0) $display("FAIL reset_rx_done: got %0b expected 0", rx_done); else passed++;
    checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %0b expected 0", frame_err); else passed++;
    checks++; if (uart_state !== 1'b0) $display("FAIL reset_uart_state: got %0b expected 0", uart_state); else passed++;
    d0 = n_done; e0 = n_err;
    rst = 1'b0;
    last_good = 8'h00;
    idle(1000);
    checks++;
    if (n_done != d0 || n_err != e0)
      $display("FAIL reset_quiet: got %0d strobes expected 0", (n_done - d0) + (n_err - e0));
    else passed++;
    checks++; if (uart_state !== 1'b0) $display("FAIL reset_idle_state: got %0b expected 0", uart_state); else passed++;
  endtask

  task automatic test_loopback;
    int e0, k;
    e0 = n_err;
    baud_set = 4'd15;
    fork
      begin send_byte(8'hA5, 32, 1'b1, -1); send_byte(8'h3C, 32, 1'b1, -1); end
      collect(2, 700);
      begin
        // Pin fall to rx_done: 3 clks to start detect, 155 ticks of 2 clks
        k = 0;
        do begin @(negedge clk); k++; end while (!rx_done && k < 400);
        checks++;
        if (k < 312 || k > 314) $display("FAIL loopback_latency: got %0d clks expected 313", k);
        else passed++;
      end
    join
    idle(40);
    checks++;
    if (n_err != e0) $display("FAIL loopback_no_err: got %0d frame_err expected 0", n_err - e0);
    else passed++;
  endtask

  task automatic test_glitch;
    int d0, e0, hi;
    d0 = n_done; e0 = n_err; hi = 0;
    baud_set = 4'd15;
    rs232_rx = 1'b0;
    idle(6);
    rs232_rx = 1'b1;
    repeat (100) begin @(negedge clk); if (uart_state) hi++; end
    checks++;
    if (hi == 0 || hi >= 32) $display("FAIL glitch_state_width: got %0d clks expected 1..31", hi);
    else passed++;
    checks++; if (n_done != d0) $display("FAIL glitch_no_done: got %0d expected 0", n_done - d0); else passed++;
    checks++; if (n_err != e0) $display("FAIL glitch_no_err: got %0d expected 0", n_err - e0); else passed++;
    #1;
  endtask

  task automatic test_framing;
    baud_set = 4'd15;
    fork
      begin send_byte(8'h55, 32, 1'b0, -1); idle(40); send_byte(8'h0F, 32, 1'b1, -1); end
      collect(2, 800);
    join
    idle(40);
  endtask

  task automatic test_noise_rate;
    baud_set = 4'd4;
    fork
      send_byte(8'hC3, 432, 1'b1, 1971);
      collect(1, 6000);
    join
    idle(100);
    fork
      send_byte(8'hC3, 450, 1'b1, 1971);
      collect(1, 6000);
    join
    idle(100);
    baud_set = 4'd15;
  endtask

  task automatic test_abort;
    baud_set = 4'd15;
    rs232_rx = 1'b0; idle(32);
    rs232_rx = 1'b1; idle(96);
    rst = 1'b1;
    #1;
    checks++; if (uart_state !== 1'b0) $display("FAIL abort_state: got %0b expected 0", uart_state); else passed++;
    checks++; if (data_byte !== 8'h00) $display("FAIL abort_data: got %02h expected 00", data_byte); else passed++;
    last_good = 8'h00;
    idle(3);
    rst = 1'b0;
    idle(40);
    fork
      send_byte(8'h81, 32, 1'b1, -1);
      begin idle(100); baud_set = 4'd0; end
      collect(1, 500);
    join
    baud_set = 4'd15;
    idle(40);
  endtask

  task automatic test_invariants;
    checks++; if (n_both != 0) $display("FAIL inv_exclusive: got %0d overlaps expected 0", n_both); else passed++;
    checks++; if (n_state_bad != 0) $display("FAIL inv_state_fall: got %0d expected 0", n_state_bad); else passed++;
    checks++; if (n_wide != 0) $display("FAIL inv_pulse_width: got %0d wide pulses expected 0", n_wide); else passed++;
    checks++; if (n_data_bad != 0) $display("FAIL inv_data_hold: got %0d stray changes expected 0", n_data_bad); else passed++;
    checks++; if (sb.size() != 0) $display("FAIL inv_scoreboard_empty: got %0d left expected 0", sb.size()); else passed++;
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_glitch;
    test_framing;
    test_noise_rate;
    test_abort;
    test_invariants;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
